// File: rtl/instr_cycle_controller.sv
// 8-phase instruction-cycle sequencer for the 8-bit RISC CPU, with optional IDLE wait cycles.
// Optional feature: define CTRL_SINGLE_STEP_EN to add the step input for single-instruction stepping.
module instr_cycle_controller #(
    parameter int OPW       = 3,
    parameter int IDLE_WAIT = 0
) (
    input  logic           clk,
    input  logic           rst_n,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic           step,
`endif
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    output logic           addr_sel,
    output logic           addr_en,
    output logic           rd,
    output logic           wr,
    output logic           ld_ir,
    output logic           inc_pc,
    output logic           ld_pc,
    output logic           ld_ac,
    output logic           data_e,
    output logic           halt,
    output logic [2:0]     phase
);

    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_t;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_t;

    if (OPW != 3) begin : g_bad_opw
        $error("instr_cycle_controller: OPW must be 3");
    end
    if (IDLE_WAIT < 0 || IDLE_WAIT > 15) begin : g_bad_idle_wait
        $error("instr_cycle_controller: IDLE_WAIT must be in 0..15");
    end

    localparam logic [3:0] WAIT_LAST = 4'(IDLE_WAIT);

    phase_t     state;
    logic       halted;
    logic [3:0] wait_cnt;
    logic       run_ok;
    logic       aluop;

`ifdef CTRL_SINGLE_STEP_EN
    assign run_ok = step;
`else
    assign run_ok = 1'b1;
`endif

    // NOTE: reset is synchronous, so rst_n is tested inside the clocked block, not in its sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= PH_INST_ADDR;
            halted   <= 1'b0;
            wait_cnt <= 4'd0;
        end else if (!halted) begin
            case (state)
                PH_INST_ADDR: if (run_ok) state <= PH_INST_FETCH;
                PH_IDLE: begin
                    if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= 4'd0;
                        state    <= PH_OP_ADDR;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                PH_OP_ADDR: begin
                    // Halting freezes the sequencer in OP_FETCH until the next reset.
                    if (opcode == OP_HLT) halted <= 1'b1;
                    state <= PH_OP_FETCH;
                end
                default: state <= phase_t'(state + 3'd1);
            endcase
        end
    end

    assign aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                   (opcode == OP_XOR) || (opcode == OP_LDA);
    assign phase = state;
    assign halt  = halted;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        addr_sel = state[2];
        addr_en  = 1'b0;
        rd       = 1'b0;
        wr       = 1'b0;
        ld_ir    = 1'b0;
        inc_pc   = 1'b0;
        ld_pc    = 1'b0;
        ld_ac    = 1'b0;
        data_e   = 1'b0;
        if (!halted) begin
            case (state)
                PH_INST_ADDR: addr_en = 1'b1;
                PH_INST_FETCH: rd = 1'b1;
                PH_INST_LOAD, PH_IDLE: begin
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    addr_en = 1'b1;
                    inc_pc  = 1'b1;
                end
                PH_OP_FETCH: rd = aluop;
                PH_ALU_OP: begin
                    rd     = aluop;
                    inc_pc = (opcode == OP_SKZ) && zero;
                    ld_pc  = (opcode == OP_JMP);
                    data_e = (opcode == OP_STO);
                end
                PH_STORE: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    ld_pc  = (opcode == OP_JMP);
                    inc_pc = (opcode == OP_JMP);
                    data_e = (opcode == OP_STO);
                    wr     = (opcode == OP_STO);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_cycle_controller.sv
// Self-checking bench for instr_cycle_controller: directed opcode cycles, random traffic and halt,
// against a position-in-instruction reference model; a second instance runs with IDLE_WAIT=3.
module tb_instr_cycle_controller;

    localparam int W3 = 3;
`ifdef CTRL_SINGLE_STEP_EN
    localparam bit STEP_MODE = 1'b1;
`else
    localparam bit STEP_MODE = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       step;
    logic [2:0] opcode;
    logic       zero;

    logic addr_sel0, addr_en0, rd0, wr0, ld_ir0, inc_pc0, ld_pc0, ld_ac0, data_e0, halt0;
    logic addr_sel3, addr_en3, rd3, wr3, ld_ir3, inc_pc3, ld_pc3, ld_ac3, data_e3, halt3;
    logic [2:0] phase0, phase3;

    instr_cycle_controller #(.OPW(3), .IDLE_WAIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
`ifdef CTRL_SINGLE_STEP_EN
        .step(step),
`endif
        .opcode(opcode), .zero(zero),
        .addr_sel(addr_sel0), .addr_en(addr_en0), .rd(rd0), .wr(wr0), .ld_ir(ld_ir0),
        .inc_pc(inc_pc0), .ld_pc(ld_pc0), .ld_ac(ld_ac0), .data_e(data_e0),
        .halt(halt0), .phase(phase0)
    );

    // Second instance runs ADD with zero=0 forever to exercise the IDLE wait.
    instr_cycle_controller #(.OPW(3), .IDLE_WAIT(W3)) dut3 (
        .clk(clk), .rst_n(rst_n),
`ifdef CTRL_SINGLE_STEP_EN
        .step(step),
`endif
        .opcode(3'd2), .zero(1'b0),
        .addr_sel(addr_sel3), .addr_en(addr_en3), .rd(rd3), .wr(wr3), .ld_ir(ld_ir3),
        .inc_pc(inc_pc3), .ld_pc(ld_pc3), .ld_ac(ld_ac3), .data_e(data_e3),
        .halt(halt3), .phase(phase3)
    );

    logic [12:0] obs0, obs3;
    assign obs0 = {addr_sel0, addr_en0, rd0, wr0, ld_ir0, inc_pc0, ld_pc0, ld_ac0, data_e0, halt0, phase0};
    assign obs3 = {addr_sel3, addr_en3, rd3, wr3, ld_ir3, inc_pc3, ld_pc3, ld_ac3, data_e3, halt3, phase3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: position within the current instruction plus a halted flag.
    int p0 = 0, p3 = 0;
    bit h0 = 1'b0, h3 = 1'b0;

    logic [7:0] pat_rd, pat_wr, pat_ldir, pat_inc, pat_ldpc, pat_ldac, pat_de;
    int run0 = 0, run3 = 0, idle_run0 = 0, idle_run3 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] ph_of(input int p, input int w);
        if (p <= 2) return 3'(p);
        if (p <= 3 + w) return 3'd3;
        return 3'(p - w);
    endfunction

    function automatic logic [12:0] exp_out(input logic [2:0] ph, input bit h,
                                            input logic [2:0] op, input logic z);
        bit alu, sel;
        alu = (op >= 3'd2) && (op <= 3'd5);
        sel = (ph >= 3'd4);
        if (h) return {sel, 1'b0, 7'b0, 1'b1, ph};
        return {sel,
                ph == 3'd0 || ph == 3'd4,
                (ph >= 3'd1 && ph <= 3'd3) || (ph >= 3'd5 && alu),
                ph == 3'd7 && op == 3'd6,
                ph == 3'd2 || ph == 3'd3,
                ph == 3'd4 || (ph == 3'd6 && op == 3'd1 && z == 1'b1) || (ph == 3'd7 && op == 3'd7),
                ph >= 3'd6 && op == 3'd7,
                ph == 3'd7 && alu,
                ph >= 3'd6 && op == 3'd6,
                1'b0,
                ph};
    endfunction

    task automatic model_step(inout int p, inout bit h, input int w, input logic [2:0] op);
        if (!rst_n) begin
            p = 0;
            h = 1'b0;
        end else if (h) begin
            p = p;
        end else if (ph_of(p, w) == 3'd4 && op == 3'd0) begin
            h = 1'b1;
            p = p + 1;
        end else if (p == 0 && STEP_MODE && !step) begin
            p = 0;
        end else begin
            p = (p + 1) % (8 + w);
        end
    endtask

    task automatic clear_pats();
        pat_rd = '0; pat_wr = '0; pat_ldir = '0; pat_inc = '0;
        pat_ldpc = '0; pat_ldac = '0; pat_de = '0;
    endtask

    // One clock: check both instances at the falling edge, then advance the model past the rising edge.
    task automatic tick();
        logic [2:0] mp;
        @(negedge clk);
        mp = ph_of(p0, 0);
        check("dut0_outputs", 32'(obs0), 32'(exp_out(mp, h0, opcode, zero)));
        check("dut3_outputs", 32'(obs3), 32'(exp_out(ph_of(p3, W3), h3, 3'd2, 1'b0)));
        pat_rd[mp] = rd0; pat_wr[mp] = wr0; pat_ldir[mp] = ld_ir0; pat_inc[mp] = inc_pc0;
        pat_ldpc[mp] = ld_pc0; pat_ldac[mp] = ld_ac0; pat_de[mp] = data_e0;
        if (phase0 === 3'd3) run0++;
        else if (run0 != 0) begin idle_run0 = run0; run0 = 0; end
        if (phase3 === 3'd3) run3++;
        else if (run3 != 0) begin idle_run3 = run3; run3 = 0; end
        @(posedge clk);
        model_step(p0, h0, 0, opcode);
        model_step(p3, h3, W3, 3'd2);
        #1;
    endtask

    initial begin
        int cnt0, cnt3;
        rst_n  = 1'b0;
        step   = 1'b1;
        opcode = 3'd2;
        zero   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_phase", 32'(phase0), 32'd0);
        check("reset_outputs", 32'(obs0), 32'h0800);
        check("reset_outputs_w3", 32'(obs3), 32'h0800);
        rst_n = 1'b1;

        // ADD
        clear_pats();
        repeat (8) tick();
        check("add_rd", 32'(pat_rd), 32'hEE);
        check("add_ld_ir", 32'(pat_ldir), 32'h0C);
        check("add_inc_pc", 32'(pat_inc), 32'h10);
        check("add_ld_ac", 32'(pat_ldac), 32'h80);
        check("add_wrap_phase", 32'(phase0), 32'd0);

        // STO
        opcode = 3'd6; clear_pats();
        repeat (8) tick();
        check("sto_data_e", 32'(pat_de), 32'hC0);
        check("sto_wr", 32'(pat_wr), 32'h80);
        check("sto_rd", 32'(pat_rd), 32'h0E);

        // SKZ with zero=1 then zero=0
        opcode = 3'd1; zero = 1'b1; clear_pats();
        repeat (8) tick();
        check("skz_z1_inc_pc", 32'(pat_inc), 32'h50);
        zero = 1'b0; clear_pats();
        repeat (8) tick();
        check("skz_z0_inc_pc", 32'(pat_inc), 32'h10);

        // JMP
        opcode = 3'd7; clear_pats();
        repeat (8) tick();
        check("jmp_ld_pc", 32'(pat_ldpc), 32'hC0);
        check("jmp_inc_pc", 32'(pat_inc), 32'h90);

        // Random traffic with occasional mid-instruction resets
        for (int i = 0; i < 400; i++) begin
            if (p0 == 0) opcode = 3'($urandom_range(1, 7));
            zero  = 1'($urandom);
            rst_n = ($urandom_range(0, 39) != 0);
            tick();
        end
        rst_n = 1'b1;

        // HLT: align to phase 0 (bounded), then halt and stay frozen
        for (int i = 0; i < 16 && p0 != 0; i++) tick();
        check("hlt_aligned", 32'(phase0), 32'd0);
        opcode = 3'd0;
        repeat (5) tick();
        check("hlt_halt", 32'(halt0), 32'd1);
        check("hlt_phase", 32'(phase0), 32'd5);
        for (int i = 0; i < 20; i++) begin
            opcode = 3'($urandom_range(0, 7));
            tick();
            check("hlt_frozen", 32'(phase0), 32'd5);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("hlt_reset_phase", 32'(phase0), 32'd0);
        check("hlt_reset_halt", 32'(halt0), 32'd0);

        // IDLE length on both instances
        opcode = 3'd2; zero = 1'b0;
        idle_run0 = 0; idle_run3 = 0;
        repeat (24) tick();
        check("idle_len_w0", 32'(idle_run0), 32'd1);
        check("idle_len_w3", 32'(idle_run3), 32'd4);

`ifdef CTRL_SINGLE_STEP_EN
        step = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("step_hold_w0", 32'(phase0), 32'd0);
        check("step_hold_w3", 32'(phase3), 32'd0);
        step = 1'b1;
        tick();
        step = 1'b0;
        cnt0 = 0; cnt3 = 0;
        for (int i = 0; i < 16; i++) begin
            if (phase0 !== 3'd0) cnt0++;
            if (phase3 !== 3'd0) cnt3++;
            tick();
        end
        check("step_one_instr_w0", 32'(cnt0), 32'd7);
        check("step_one_instr_w3", 32'(cnt3), 32'd10);
`else
        cnt0 = 0; cnt3 = 0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
